// File: rtl/uram_update_ctrl.sv
// uram_update_ctrl: init / accumulate / sweep sequencer for the destination-vertex URAM stage.
module uram_update_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 72,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vertices,
    input  logic [DATA_W-1:0] init_val,
    input  logic              edge_valid,
    output logic              edge_ready,
    input  logic [ADDR_W-1:0] edge_dst,
    input  logic [DATA_W-1:0] edge_val,
    input  logic              edge_last,
    output logic [2:0]        ram_mode,
    output logic              ram_valid,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [DATA_W-1:0] ram_dinb,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              res_last,
    output logic              busy,
    output logic              done
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ONE = 1;
    localparam logic [CW-1:0] TWO = 2;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_UPDATE = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] M_IDLE   = 3'b000;
    localparam logic [2:0] M_INIT   = 3'b001;
    localparam logic [2:0] M_UPD    = 3'b010;
    localparam logic [2:0] M_READ   = 3'b011;
    logic [2:0]        state;
    logic [CW-1:0]     n_q;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] init_q;
    logic              hz_v;
    logic [ADDR_W-1:0] hz_dst;
    logic [RD_LAT:0]   pv;
    logic [ADDR_W-1:0] pa [RD_LAT+1];
    logic              pl [RD_LAT+1];
    logic              hazard;
    logic              oor;
    logic [CW-1:0]     cnt_p1;
    logic              rd_last;
    // the RAM writes back one cycle after an update, so a repeat of the last dst must wait
    assign hazard     = edge_valid && hz_v && (edge_dst == hz_dst);
    assign edge_ready = (state == S_UPDATE) && !hazard;
    assign oor        = {1'b0, edge_dst} >= n_q;
    assign cnt_p1     = cnt + ONE;
    assign rd_last    = cnt_p1 == n_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            n_q       <= '0;
            cnt       <= '0;
            init_q    <= '0;
            hz_v      <= 1'b0;
            hz_dst    <= '0;
            pv        <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                pa[k] <= '0;
                pl[k] <= 1'b0;
            end
            ram_mode  <= M_IDLE;
            ram_valid <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            ram_addrb <= '0;
            ram_dinb  <= '0;
            res_valid <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            res_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ram_valid <= 1'b0;
            ram_mode  <= M_IDLE;
            done      <= 1'b0;
            pv        <= {pv[RD_LAT-1:0], 1'b0};
            for (int k = RD_LAT; k > 0; k--) begin
                pa[k] <= pa[k-1];
                pl[k] <= pl[k-1];
            end
            res_valid <= pv[RD_LAT];
            res_last  <= pv[RD_LAT] & pl[RD_LAT];
            res_addr  <= pa[RD_LAT];
            res_data  <= ram_douta;
            case (state)
                S_IDLE: if (start) begin
                    n_q    <= num_vertices;
                    init_q <= init_val;
                    busy   <= 1'b1;
                    cnt    <= '0;
                    hz_v   <= 1'b0;
                    state  <= (num_vertices == '0) ? S_DONE : S_INIT;
                end
                S_INIT: begin
                    ram_valid <= 1'b1;
                    ram_mode  <= M_INIT;
                    ram_addra <= cnt[ADDR_W-1:0];
                    ram_addrb <= (cnt_p1 < n_q) ? cnt_p1[ADDR_W-1:0] : cnt[ADDR_W-1:0];
                    ram_dina  <= init_q;
                    ram_dinb  <= init_q;
                    cnt       <= cnt + TWO;
                    state     <= (cnt + TWO >= n_q) ? S_UPDATE : S_INIT;
                end
                S_UPDATE: begin
                    ram_valid <= 1'b1;
                    hz_v      <= 1'b0;
                    if (edge_valid && edge_ready) begin
                        if (!oor) begin
                            ram_mode  <= M_UPD;
                            ram_addra <= edge_dst;
                            ram_dina  <= edge_val;
                            hz_v      <= 1'b1;
                            hz_dst    <= edge_dst;
                        end
                        if (edge_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    ram_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= S_READ;
                end
                S_READ: begin
                    ram_valid <= 1'b1;
                    ram_mode  <= M_READ;
                    ram_addra <= cnt[ADDR_W-1:0];
                    ram_addrb <= cnt[ADDR_W-1:0];
                    pv[0]     <= 1'b1;
                    pa[0]     <= cnt[ADDR_W-1:0];
                    pl[0]     <= rd_last;
                    cnt       <= cnt_p1;
                    state     <= rd_last ? S_FLUSH : S_READ;
                end
                S_FLUSH: state <= (pv == '0) ? S_DONE : S_FLUSH;
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uram_update_ctrl.sv
// tb_uram_update_ctrl: directed bench with a small RAM-stage model (one-cycle write-back delay).
module tb_uram_update_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [16:0] num_vertices = '0;
    logic [71:0] init_val = '0;
    logic        edge_valid = 1'b0;
    logic        edge_ready;
    logic [15:0] edge_dst = '0;
    logic [71:0] edge_val = '0;
    logic        edge_last = 1'b0;
    logic [2:0]  ram_mode;
    logic        ram_valid;
    logic [15:0] ram_addra, ram_addrb;
    logic [71:0] ram_dina, ram_dinb;
    logic [71:0] ram_douta = '0;
    logic        res_valid;
    logic [15:0] res_addr;
    logic [71:0] res_data;
    logic        res_last;
    logic        busy, done;

    uram_update_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_vertices(num_vertices), .init_val(init_val),
        .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_dst(edge_dst), .edge_val(edge_val),
        .edge_last(edge_last), .ram_mode(ram_mode), .ram_valid(ram_valid), .ram_addra(ram_addra),
        .ram_dina(ram_dina), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_douta(ram_douta),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM stage model: updates read the old value and commit one cycle later
    logic [71:0] mem [16];
    logic        pend = 1'b0;
    logic [3:0]  pend_a = '0;
    logic [71:0] pend_v = '0;
    always @(posedge clk) begin
        if (pend) mem[pend_a] <= pend_v;
        pend <= 1'b0;
        if (ram_valid) begin
            if (ram_mode == 3'b001) begin
                mem[ram_addra[3:0]] <= ram_dina;
                mem[ram_addrb[3:0]] <= ram_dinb;
            end
            if (ram_mode == 3'b010) begin
                pend   <= 1'b1;
                pend_a <= ram_addra[3:0];
                pend_v <= mem[ram_addra[3:0]] + ram_dina;
            end
            if (ram_mode == 3'b011) ram_douta <= mem[ram_addra[3:0]];
        end
    end

    logic        clr = 1'b0;
    logic [71:0] got [16];
    int          res_cnt, last_cnt, done_cnt, rv_cnt, busy_cnt, ic;
    logic [15:0] last_addr;
    logic [15:0] init_a [8];
    logic [15:0] init_b [8];
    always @(negedge clk) begin
        if (clr) begin
            res_cnt <= 0; last_cnt <= 0; done_cnt <= 0; rv_cnt <= 0; busy_cnt <= 0; ic <= 0;
            last_addr <= '0;
        end else begin
            if (res_valid) begin
                got[res_addr[3:0]] <= res_data;
                res_cnt <= res_cnt + 1;
            end
            if (res_valid && res_last) begin
                last_cnt  <= last_cnt + 1;
                last_addr <= res_addr;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (ram_valid) rv_cnt <= rv_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (ram_valid && ram_mode == 3'b001 && ic < 8) begin
                init_a[ic] <= ram_addra;
                init_b[ic] <= ram_addrb;
                ic <= ic + 1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int wt [8];
    int ei = 0;

    task automatic chk(input string tag, input logic [71:0] got_v, input logic [71:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    task automatic start_job(input logic [16:0] n, input logic [71:0] iv);
        @(posedge clk); #1;
        clr = 1'b1; start = 1'b1; num_vertices = n; init_val = iv; ei = 0;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
    endtask

    task automatic send_edge(input logic [15:0] d, input logic [71:0] v, input logic l);
        int w;
        bit ok;
        w = 0; ok = 0;
        edge_valid = 1'b1; edge_dst = d; edge_val = v; edge_last = l;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (edge_ready) begin ok = 1; break; end
            w++;
        end
        if (!ok) chk("edge_timeout", 0, 1);
        if (ei < 8) wt[ei] = w;
        ei++;
        @(posedge clk); #1;
        edge_valid = 1'b0; edge_last = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, ram_valid, ram_mode, edge_ready, res_valid, res_last}, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", {busy, done, ram_valid, edge_ready}, '0);

        // abort a job mid-UPDATE with an asynchronous reset
        start_job(17'd4, 72'd0);
        send_edge(16'd1, 72'd3, 1'b0);
        edge_valid = 1'b1; edge_dst = 16'd2;
        #1;
        chk("pre_rst_busy_ready", {busy, edge_ready}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outs", {busy, done, ram_valid, ram_mode, edge_ready, res_valid, res_last}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; edge_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy, ram_valid, edge_ready}, '0);

        // N=5, init 7, lone dropped last edge
        start_job(17'd5, 72'd7);
        send_edge(16'd9, 72'd100, 1'b1);
        wait_done();
        chk("a_init_cycles", ic, 3);
        chk("a_init0", {init_a[0], init_b[0]}, {16'd0, 16'd1});
        chk("a_init1", {init_a[1], init_b[1]}, {16'd2, 16'd3});
        chk("a_init2", {init_a[2], init_b[2]}, {16'd4, 16'd4});
        chk("a_res_cnt", res_cnt, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("a_res%0d", i), got[i], 72'd7);
        chk("a_last", {last_cnt[7:0], last_addr}, {8'd1, 16'd4});
        chk("a_done_cnt", done_cnt, 1);
        chk("a_idle", busy, 1'b0);

        // N=4, init 0, no stalls; stray start with a new N while busy must be ignored
        start_job(17'd4, 72'd0);
        start = 1'b1; num_vertices = 17'd2; init_val = 72'd99;
        @(posedge clk); #1 start = 1'b0;
        send_edge(16'd1, 72'd3, 1'b0);
        send_edge(16'd2, 72'd5, 1'b0);
        send_edge(16'd1, 72'd4, 1'b1);
        wait_done();
        chk("b_wait1", wt[1], 0);
        chk("b_wait2", wt[2], 0);
        chk("b_res_cnt", res_cnt, 4);
        chk("b_res0", got[0], 72'd0);
        chk("b_res1", got[1], 72'd7);
        chk("b_res2", got[2], 72'd5);
        chk("b_res3", got[3], 72'd0);
        chk("b_last", last_addr, 16'd3);
        chk("b_done_cnt", done_cnt, 1);

        // back-to-back updates to the same vertex
        start_job(17'd4, 72'd10);
        send_edge(16'd3, 72'd1, 1'b0);
        send_edge(16'd3, 72'd1, 1'b0);
        send_edge(16'd3, 72'd1, 1'b1);
        wait_done();
        chk("c_wait1", wt[1], 1);
        chk("c_wait2", wt[2], 1);
        chk("c_res3", got[3], 72'd13);
        chk("c_res0", got[0], 72'd10);
        chk("c_res_cnt", res_cnt, 4);

        // N=0: straight to done
        start_job(17'd0, 72'd5);
        repeat (6) @(negedge clk);
        chk("z_busy_cycles", busy_cnt, 1);
        chk("z_done_cnt", done_cnt, 1);
        chk("z_ram_valid", rv_cnt, 0);
        chk("z_res_valid", res_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uram_update_ctrl.md
Name: uram_update_ctrl

Overview:
- Sequencer that drives the destination-vertex URAM read/modify/write stage.
- Per job it runs three phases:
  - initialise vertex values 0..N-1 to a constant;
  - stream incoming (dst, delta) edge updates into the RAM as accumulate operations;
  - sweep the RAM and emit the final per-vertex values as a result stream.
- Sits directly upstream of the URAM read/write stage: it drives that stage's mode/valid/addr/data inputs and consumes its port-A read data.

Parameters:
- ADDR_W, 16, vertex address width.
- DATA_W, 72, vertex value / delta width.
- RD_LAT, 1, cycles from issuing a mode-011 read to valid ram_douta.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a job when idle.
- num_vertices  in  ADDR_W+1  vertex count N, sampled on accepted start.
- init_val  in  DATA_W  initial vertex value, sampled on accepted start.
- edge_valid  in  1  edge update present.
- edge_ready  out  1  edge update accepted this cycle when valid&ready.
- edge_dst  in  ADDR_W  destination vertex of the update.
- edge_val  in  DATA_W  delta to add.
- edge_last  in  1  final edge of the job.
- ram_mode  out  3  000 idle, 001 init, 010 update, 011 read.
- ram_valid  out  1  qualifies ram_mode.
- ram_addra  out  ADDR_W  port A address / update address.
- ram_dina  out  DATA_W  port A data.
- ram_addrb  out  ADDR_W  port B address.
- ram_dinb  out  DATA_W  port B data.
- ram_douta  in  DATA_W  read data from the RAM stage.
- res_valid  out  1  result beat valid; no backpressure.
- res_addr  out  ADDR_W  vertex index of the result.
- res_data  out  DATA_W  final vertex value.
- res_last  out  1  last result beat.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: state IDLE; every output is 0, including edge_ready, ram_mode, ram_valid, res_*, busy and done. Any in-flight job is aborted and the read pipeline is flushed.
- All ram_* and res_* outputs are registered.
- States: IDLE, INIT, UPDATE, DRAIN, READ, FLUSH, DONE.
- IDLE:
  - ram_valid=0.
  - start=1 latches N and init_val, sets busy=1, and moves to INIT.
  - If N=0, go directly to DONE instead.
  - start outside IDLE is ignored.
- INIT:
  - Counter i from 0 in steps of 2. Each cycle drives mode 001, valid 1, addra=i, dina=init_val.
  - addrb=i+1 if i+1<N, else addrb=i. dinb=init_val.
  - Takes ceil(N/2) cycles, then moves to UPDATE.
- UPDATE:
  - edge_ready=1 except in a hazard cycle.
  - Hazard: the edge's edge_dst equals the dst issued in the immediately preceding cycle, because the RAM read-modify-write has a one-cycle write-back delay.
  - On a hazard: edge_ready=0 for one cycle and mode 000 valid 1 is issued, so the pending write commits. The edge is accepted the following cycle.
  - On an accepted edge: mode 010, valid 1, addra=edge_dst, dina=edge_val.
  - Cycles with no edge present issue mode 000 valid 1 and clear the hazard tracker.
  - edge_dst ≥ N: the edge is accepted and dropped; mode 000 is issued and the hazard tracker is cleared.
  - Accepting an edge with edge_last=1 moves to DRAIN.
- DRAIN: one cycle of mode 000 valid 1 to commit the final write, then READ.
- READ:
  - Counter j from 0 to N-1. Each cycle drives mode 011, valid 1, addra=j, addrb=j.
  - j is pushed into an RD_LAT-deep delay line together with a last flag (j==N-1).
  - After j=N-1, move to FLUSH.
- FLUSH: ram_valid=0; wait until the delay line is empty, then DONE.
- Result output: when a delay-line entry emerges, the following are driven for one cycle:
  - res_valid=1;
  - res_addr=j;
  - res_data=ram_douta;
  - res_last=the entry's last flag.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Widths: N up to 2^ADDR_W. Counters are ADDR_W+1 bits wide, so N=65536 does not wrap. Addition is performed by the RAM stage; this block never modifies data.

Test Plan:
- Reset mid-UPDATE (rst low 2 cycles) -> all outputs 0 asynchronously, state IDLE, a new start runs normally.
- N=5, init_val=7, no edges (edge_last alone arrives as dst=9, dropped):
  - INIT drives addra/addrb pairs (0,1), (2,3), (4,4) over 3 cycles;
  - results addr 0..4 all read 7;
  - res_last on addr 4; done pulses once.
- N=4, init 0, edges (1,+3), (2,+5), (1,+4 last) -> no stalls; results 0, 7, 5, 0.
- Back-to-back same dst: (3,+1), (3,+1), (3,+1 last), N=4, init 10 -> edge_ready deasserted one cycle before each repeat; result addr3=13.
- N=0 start -> busy one cycle, done pulse, no ram_valid, no res_valid.
- start pulsed while busy -> ignored; num_vertices change mid-job has no effect.
